// File: rtl/mem_lane_unit.sv
// Load/store lane steering between the MIPS execute stage and an Avalon-MM data bus.
// Build option MEM_LANE_SPLIT_EN: misaligned/spanning H/W accesses run as two bus beats.
module mem_lane_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [5:0]              req_opcode,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_rt,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic [31:0]             avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  input  logic [DATA_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_waitrequest,
  output logic [1:0]              dbg_state
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFS = $clog2(BE_WIDTH);
`ifdef MEM_LANE_SPLIT_EN
  localparam int NBEAT = 2;
`else
  localparam int NBEAT = 1;
`endif

  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LWL = 6'h22, OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2, S_RESP} state_t;
  state_t state, state_d;

  logic [5:0]  op_q, cur_op;
  logic [31:0] addr_q, rt_q, cur_addr, cur_rt;
  logic is_lb, is_lbu, is_lh, is_lhu, is_lw, is_lwl, is_lwr, is_sb, is_sh, is_sw;
  logic is_load, is_store, misaligned, accept_err;
  logic [OFS-1:0] offset;
  int off_i, k_i, wbase_i, size_i;
  logic [NBEAT*BE_WIDTH-1:0]   lane_mask, wide_be;
  logic [NBEAT*DATA_WIDTH-1:0] wide_wd;
  logic [31:0] rt_sized, word, raw_next, result;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [31:0] addr_d;
  logic rd_d, wr_d, rsp_err_d;
  logic [BE_WIDTH-1:0] be_d;
  logic [DATA_WIDTH-1:0] wd_d;
  logic [31:0] rsp_data_d;
`ifdef MEM_LANE_SPLIT_EN
  logic spans;
  logic [31:0] raw_q;
`endif

  // In IDLE the request ports are decoded directly; afterwards the latched copy is used.
  always_comb begin
    cur_op   = (state == S_IDLE) ? req_opcode : op_q;
    cur_addr = (state == S_IDLE) ? req_addr : addr_q;
    cur_rt   = (state == S_IDLE) ? req_rt : rt_q;
  end

  assign is_lb  = (cur_op == OP_LB);
  assign is_lbu = (cur_op == OP_LBU);
  assign is_lh  = (cur_op == OP_LH);
  assign is_lhu = (cur_op == OP_LHU);
  assign is_lw  = (cur_op == OP_LW);
  assign is_lwl = (cur_op == OP_LWL);
  assign is_lwr = (cur_op == OP_LWR);
  assign is_sb  = (cur_op == OP_SB);
  assign is_sh  = (cur_op == OP_SH);
  assign is_sw  = (cur_op == OP_SW);
  assign is_load  = is_lb | is_lbu | is_lh | is_lhu | is_lw | is_lwl | is_lwr;
  assign is_store = is_sb | is_sh | is_sw;
  assign offset   = cur_addr[OFS-1:0];

  always_comb begin
    off_i   = int'(offset);
    k_i     = int'(cur_addr[1:0]);
    wbase_i = off_i & ~3;
    size_i  = (is_lb | is_lbu | is_sb) ? 1 : (is_lh | is_lhu | is_sh) ? 2 : 4;
    misaligned = ((is_lh | is_lhu | is_sh) && offset[0]) ||
                 ((is_lw | is_sw) && (cur_addr[1:0] != 2'b00));
`ifdef MEM_LANE_SPLIT_EN
    spans = (off_i + size_i) > BE_WIDTH;
    accept_err = !(is_load | is_store);
`else
    accept_err = !(is_load | is_store) || misaligned;
`endif
    // LWL/LWR touch only their own word; other accesses use a contiguous size mask.
    if (is_lwl) begin
      lane_mask = (NBEAT*BE_WIDTH)'((2 << k_i) - 1);
      wide_be   = lane_mask << wbase_i;
    end else if (is_lwr) begin
      lane_mask = (NBEAT*BE_WIDTH)'((15 << k_i) & 15);
      wide_be   = lane_mask << wbase_i;
    end else begin
      lane_mask = (NBEAT*BE_WIDTH)'((1 << size_i) - 1);
      wide_be   = lane_mask << off_i;
    end
    case (size_i)
      1:       rt_sized = {24'b0, cur_rt[7:0]};
      2:       rt_sized = {16'b0, cur_rt[15:0]};
      default: rt_sized = cur_rt;
    endcase
    wide_wd = is_store ? ((NBEAT*DATA_WIDTH)'(rt_sized) << (8 * off_i)) : '0;
  end

  // Beat data assembly: beat 1 supplies the low result bytes, beat 2 the rest.
  always_comb begin
    word     = 32'(avm_readdata >> (8 * wbase_i));
    rd_shift = avm_readdata >> (8 * off_i);
    if (is_lwl || is_lwr) raw_next = word;
    else                  raw_next = 32'(rd_shift);
`ifdef MEM_LANE_SPLIT_EN
    if (state == S_BEAT2)
      raw_next = raw_q | 32'(avm_readdata << (8 * (BE_WIDTH - off_i)));
`endif
    result = '0;
    if (is_lb)       result = {{24{raw_next[7]}}, raw_next[7:0]};
    else if (is_lbu) result = {24'b0, raw_next[7:0]};
    else if (is_lh)  result = {{16{raw_next[15]}}, raw_next[15:0]};
    else if (is_lhu) result = {16'b0, raw_next[15:0]};
    else if (is_lw)  result = raw_next;
    else if (is_lwl) result = (raw_next << (8 * (3 - k_i))) |
                              (cur_rt & (32'hFFFF_FFFF >> (8 * (k_i + 1))));
    else if (is_lwr) result = (raw_next >> (8 * k_i)) |
                              (cur_rt & ~(32'hFFFF_FFFF >> (8 * k_i)));
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (req_valid) state_d = accept_err ? S_RESP : S_BEAT1;
      S_BEAT1: if (!avm_waitrequest) begin
`ifdef MEM_LANE_SPLIT_EN
        state_d = spans ? S_BEAT2 : S_RESP;
`else
        state_d = S_RESP;
`endif
      end
      S_BEAT2: if (!avm_waitrequest) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus/response outputs; they move only on state entry or beat completion.
  always_comb begin
    addr_d     = avm_address;
    rd_d       = avm_read;
    wr_d       = avm_write;
    be_d       = avm_byteenable;
    wd_d       = avm_writedata;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    case (state)
      S_IDLE: if (req_valid) begin
        if (accept_err) begin
          rsp_err_d = 1'b1;
        end else begin
          addr_d = {cur_addr[31:OFS], {OFS{1'b0}}};
          rd_d   = is_load;
          wr_d   = is_store;
          be_d   = wide_be[BE_WIDTH-1:0];
          wd_d   = wide_wd[DATA_WIDTH-1:0];
        end
      end
      S_BEAT1: if (!avm_waitrequest) begin
`ifdef MEM_LANE_SPLIT_EN
        if (spans) begin
          addr_d = avm_address + 32'(BE_WIDTH);
          be_d   = wide_be[2*BE_WIDTH-1:BE_WIDTH];
          wd_d   = wide_wd[2*DATA_WIDTH-1:DATA_WIDTH];
        end else
`endif
        begin
          rd_d = 1'b0; wr_d = 1'b0; be_d = '0; wd_d = '0;
          rsp_data_d = result;
        end
      end
`ifdef MEM_LANE_SPLIT_EN
      S_BEAT2: if (!avm_waitrequest) begin
        rd_d = 1'b0; wr_d = 1'b0; be_d = '0; wd_d = '0;
        rsp_data_d = result;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      op_q           <= '0;
      addr_q         <= '0;
      rt_q           <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
`ifdef MEM_LANE_SPLIT_EN
      raw_q          <= '0;
`endif
    end else begin
      state          <= state_d;
      avm_address    <= addr_d;
      avm_read       <= rd_d;
      avm_write      <= wr_d;
      avm_byteenable <= be_d;
      avm_writedata  <= wd_d;
      rsp_data       <= rsp_data_d;
      rsp_err        <= rsp_err_d;
      if (state == S_IDLE && req_valid) begin
        op_q   <= req_opcode;
        addr_q <= req_addr;
        rt_q   <= req_rt;
      end
`ifdef MEM_LANE_SPLIT_EN
      if (state == S_BEAT1 && !avm_waitrequest) raw_q <= raw_next;
`endif
    end
  end

  assign req_ready = (state == S_IDLE) && !reset;
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;
endmodule
